// File: rtl/exp3_fluxo_dados.sv
// Datapath for the memory game: address counter, 16x4 pattern ROM, key
// register with a synchronized key input and a single-pulse press detector.
module exp3_fluxo_dados (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       zeraC,
  input  logic       contaC,
  input  logic       zeraR,
  input  logic       registraR,
  input  logic [3:0] chaves,
  output logic       fimC,
  output logic       chavesIgualMemoria,
  output logic       jogada_feita,
  output logic [3:0] db_contagem,
  output logic [3:0] db_memoria,
  output logic [3:0] db_chaves,
  output logic       db_tem_jogada
);

  logic [3:0] contagem_r;
  logic [3:0] chave_reg_r;
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic       tem_prev_r;
  logic       jogada_r;
  logic [3:0] memoria_s;
  logic       tem_jogada_s;

  function automatic logic [3:0] rom_word(input logic [3:0] addr);
    case (addr)
      4'd0:    rom_word = 4'h1;
      4'd1:    rom_word = 4'h2;
      4'd2:    rom_word = 4'h4;
      4'd3:    rom_word = 4'h8;
      4'd4:    rom_word = 4'h4;
      4'd5:    rom_word = 4'h2;
      4'd6:    rom_word = 4'h1;
      4'd7:    rom_word = 4'h1;
      4'd8:    rom_word = 4'h2;
      4'd9:    rom_word = 4'h2;
      4'd10:   rom_word = 4'h4;
      4'd11:   rom_word = 4'h4;
      4'd12:   rom_word = 4'h8;
      4'd13:   rom_word = 4'h8;
      4'd14:   rom_word = 4'h1;
      4'd15:   rom_word = 4'h4;
      default: rom_word = 4'h0;
    endcase
  endfunction

  // Address counter: clear wins over count, wraps naturally at 15
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem_r <= 4'd0;
    end else if (zeraC) begin
      contagem_r <= 4'd0;
    end else if (contaC) begin
      contagem_r <= contagem_r + 4'd1;
    end else begin
      contagem_r <= contagem_r;
    end
  end

  // Key register: clear wins over load, loads only the synchronized keys
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chave_reg_r <= 4'd0;
    end else if (zeraR) begin
      chave_reg_r <= 4'd0;
    end else if (registraR) begin
      chave_reg_r <= sync2_r;
    end else begin
      chave_reg_r <= chave_reg_r;
    end
  end

  // Two-flop synchronizer plus a registered rising-edge pulse on "any key"
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r    <= 4'd0;
      sync2_r    <= 4'd0;
      tem_prev_r <= 1'b0;
      jogada_r   <= 1'b0;
    end else begin
      sync1_r    <= chaves;
      sync2_r    <= sync1_r;
      tem_prev_r <= tem_jogada_s;
      jogada_r   <= tem_jogada_s & ~tem_prev_r;
    end
  end

  assign memoria_s          = rom_word(contagem_r);
  assign tem_jogada_s       = |sync2_r;
  assign fimC               = (contagem_r == 4'd15);
  assign chavesIgualMemoria = (chave_reg_r == memoria_s);
  assign jogada_feita       = jogada_r;
  assign db_contagem        = contagem_r;
  assign db_memoria         = memoria_s;
  assign db_chaves          = chave_reg_r;
  assign db_tem_jogada      = tem_jogada_s;

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Scoreboard bench for exp3_fluxo_dados: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_exp3_fluxo_dados;

  logic       clock;
  logic       reset_n;
  logic       zeraC, contaC, zeraR, registraR;
  logic [3:0] chaves;
  logic       fimC, chavesIgualMemoria, jogada_feita, db_tem_jogada;
  logic [3:0] db_contagem, db_memoria, db_chaves;

  exp3_fluxo_dados dut (
    .clock(clock), .reset_n(reset_n),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .chaves(chaves),
    .fimC(fimC), .chavesIgualMemoria(chavesIgualMemoria), .jogada_feita(jogada_feita),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_chaves(db_chaves),
    .db_tem_jogada(db_tem_jogada)
  );

  // care mask bits: [6]cnt [5]mem [4]chv [3]fim [2]igual [1]jog [0]tem
  localparam logic [6:0] C_CNT = 7'h40, C_MEM = 7'h20, C_CHV = 7'h10, C_FIM = 7'h08;
  localparam logic [6:0] C_IGU = 7'h04, C_JOG = 7'h02, C_TEM = 7'h01, C_ALL = 7'h7F;

  typedef struct {
    string      name;
    logic [6:0] care;
    logic [3:0] cnt, mem, chv;
    logic       fim, igual, jog, tem;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [3:0] rom_tb [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                              4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic push(input string nm, input logic [6:0] care, input logic [3:0] cnt,
                      input logic [3:0] mem, input logic [3:0] chv, input logic fim,
                      input logic igual, input logic jog, input logic tem);
    exp_t e;
    e.name = nm; e.care = care; e.cnt = cnt; e.mem = mem; e.chv = chv;
    e.fim = fim; e.igual = igual; e.jog = jog; e.tem = tem;
    sb.push_back(e);
  endtask

  task automatic push_cnt(input string nm, input logic [3:0] c);
    push(nm, C_CNT | C_MEM | C_FIM, c, rom_tb[c], 4'd0, (c == 4'd15), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_reset(input string nm);
    push(nm, C_ALL, 4'd0, 4'h1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h at %0t", nm, fld, act, expv, $time);
  endtask

  // Monitor: compare every pending expectation against the settled outputs
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.care[6]) cmp(e.name, "db_contagem", db_contagem, e.cnt);
      if (e.care[5]) cmp(e.name, "db_memoria", db_memoria, e.mem);
      if (e.care[4]) cmp(e.name, "db_chaves", db_chaves, e.chv);
      if (e.care[3]) cmp(e.name, "fimC", {3'b000, fimC}, {3'b000, e.fim});
      if (e.care[2]) cmp(e.name, "chavesIgualMemoria", {3'b000, chavesIgualMemoria}, {3'b000, e.igual});
      if (e.care[1]) cmp(e.name, "jogada_feita", {3'b000, jogada_feita}, {3'b000, e.jog});
      if (e.care[0]) cmp(e.name, "db_tem_jogada", {3'b000, db_tem_jogada}, {3'b000, e.tem});
    end
  end

  initial begin
    reset_n = 1'b0; zeraC = 1'b0; contaC = 1'b0; zeraR = 1'b0; registraR = 1'b0;
    chaves  = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    push_reset("reset");
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    // counting 1..15 then wrap to 0
    contaC = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      push_cnt("count", i[3:0]);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      push_cnt("count7", i[3:0]);
    end
    zeraC = 1'b1;
    tick();
    push_cnt("clr_prio", 4'd0);
    zeraC = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      push_cnt("count3", i[3:0]);
    end
    contaC = 1'b0;
    tick();
    push_cnt("hold", 4'd3);

    // compare pass/fail at address 3
    chaves = 4'b1000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      push("press_1000", C_CHV | C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, (k == 3), (k >= 2));
    end
    registraR = 1'b1;
    tick();
    registraR = 1'b0;
    push("cmp_pass", C_ALL, 4'd3, 4'h8, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);
    chaves = 4'b0100;
    for (int k = 1; k <= 2; k++) begin
      tick();
      push("swap_nopulse", C_CHV | C_IGU | C_JOG | C_TEM, 4'd0, 4'd0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    registraR = 1'b1;
    tick();
    registraR = 1'b0;
    push("cmp_fail", C_ALL, 4'd3, 4'h8, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);

    // counter and register commanded together
    contaC = 1'b1; registraR = 1'b1;
    tick();
    contaC = 1'b0; registraR = 1'b0;
    push("both", C_ALL, 4'd4, 4'h4, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1);

    // register clear priority
    chaves = 4'b1111;
    for (int k = 1; k <= 2; k++) begin
      tick();
      push("to_1111", C_CHV | C_JOG | C_TEM, 4'd0, 4'd0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    zeraR = 1'b1; registraR = 1'b1;
    tick();
    zeraR = 1'b0; registraR = 1'b0;
    push("reg_prio", C_ALL, 4'd4, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // press edge behaviour
    chaves = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      push("release_a", C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, (k == 1));
    end
    chaves = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      push("press_0010", C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, (k == 3), (k >= 2));
    end
    chaves = 4'b0110;
    for (int k = 1; k <= 5; k++) begin
      tick();
      push("change_0110", C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chaves = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      push("release_b", C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, (k == 1));
    end
    chaves = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      tick();
      push("press_0001", C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, (k == 3), (k >= 2));
    end
    chaves = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      push("release_c", C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, (k == 1));
    end

    // set up count 9 with key register 4
    contaC = 1'b1;
    for (int i = 5; i <= 9; i++) begin
      tick();
      push_cnt("count9", i[3:0]);
    end
    contaC = 1'b0;
    chaves = 4'b0100;
    for (int k = 1; k <= 2; k++) begin
      tick();
      push("press_0100", C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, (k == 2));
    end
    registraR = 1'b1;
    tick();
    registraR = 1'b0;
    push("load4", C_ALL, 4'd9, 4'h2, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1);
    chaves = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      push("release_d", C_JOG | C_TEM, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, (k == 1));
    end

    // new press with a pulse pending, then async reset between edges
    chaves = 4'b0100;
    tick();
    push("pend1", C_CNT | C_CHV | C_JOG | C_TEM, 4'd9, 4'd0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    reset_n = 1'b0;
    push_reset("async_rst");
    tick();
    push_reset("rst_hold");
    @(negedge clock);
    #1;
    reset_n = 1'b1; chaves = 4'b0000; contaC = 1'b1;
    tick();
    contaC = 1'b0;
    push("resume", C_ALL, 4'd1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    push("resume_hold", C_CNT | C_JOG | C_TEM, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exp3_fluxo_dados.md
EXP3_FLUXO_DADOS -- requirements
Module: exp3_fluxo_dados

Interface
REQ-001 The block SHALL be the datapath paired with the game control unit, consuming its zeraC/contaC/zeraR/registraR and producing its fimC/chavesIgualMemoria.
REQ-002 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-003 Port: clock  input  1  rising-edge system clock.
REQ-004 Port: reset_n  input  1  asynchronous reset, active-low.
REQ-005 Port: zeraC  input  1  synchronous clear of the address counter.
REQ-006 Port: contaC  input  1  increment the address counter.
REQ-007 Port: zeraR  input  1  synchronous clear of the key register.
REQ-008 Port: registraR  input  1  load chaves into the key register.
REQ-009 Port: chaves  input  4  player key switches, asynchronous to clock.
REQ-010 Port: fimC  output  1  address counter equals 15.
REQ-011 Port: chavesIgualMemoria  output  1  key register equals ROM word at current address.
REQ-012 Port: jogada_feita  output  1  one-cycle pulse on a new key press.
REQ-013 Port: db_contagem  output  4  address counter value.
REQ-014 Port: db_memoria  output  4  ROM word at current address.
REQ-015 Port: db_chaves  output  4  key register value.
REQ-016 Port: db_tem_jogada  output  1  synchronized OR of chaves.

Function
REQ-017 Address counter SHALL be 4-bit unsigned; zeraC has priority over contaC; contaC increments by 1 per cycle; 15 + 1 wraps to 0; it holds when neither is asserted.
REQ-018 fimC SHALL be combinational and equal to (counter == 15).
REQ-019 ROM SHALL be 16x4, read combinationally. Contents for addresses 0..15 in hex: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
REQ-020 Key register SHALL be 4-bit; zeraR has priority over registraR; registraR loads the 2-stage-synchronized chaves value; it holds otherwise.
REQ-021 chavesIgualMemoria SHALL be combinational: 1 when the key register equals ROM[counter], else 0.
REQ-022 chaves SHALL pass through a 2-flop synchronizer before any use; db_tem_jogada SHALL be the OR of the synchronized bits.
REQ-023 jogada_feita SHALL pulse high for exactly one cycle on a 0->1 transition of db_tem_jogada, 3 cycles after chaves changes.
REQ-024 A sustained press SHALL give one pulse only; the next pulse requires release to 0000 for at least one synchronized cycle.
REQ-025 Changes between nonzero key values, with no release, SHALL NOT generate a pulse.
REQ-026 Counter and register SHALL update independently in the same cycle when both are commanded.
REQ-027 Debug outputs SHALL mirror internal values with no added latency.

Reset
REQ-028 While reset_n = 0, counter, key register, synchronizer flops and edge-detect flop SHALL be 0 immediately, regardless of clock.
REQ-029 Values after reset SHALL be: fimC = 0, db_contagem = 0, db_chaves = 0, db_memoria = 1, chavesIgualMemoria = 0, jogada_feita = 0, db_tem_jogada = 0.
REQ-030 Asserting reset_n mid-operation SHALL abort any pending jogada_feita pulse.
REQ-031 After reset_n deasserts, operation SHALL resume on the first rising clock edge.

Verification
REQ-032 Counting and wrap: reset, then contaC for 15 cycles -> db_contagem = 15, fimC = 1; one more contaC -> db_contagem = 0, fimC = 0.
REQ-033 Clear priority: zeraC = 1 and contaC = 1 together at count 7 -> count becomes 0.
REQ-034 Compare pass and fail: address 3, chaves = 1000 held 3 cycles, registraR pulse -> db_chaves = 8, chavesIgualMemoria = 1; chaves = 0100, registraR -> chavesIgualMemoria = 0.
REQ-035 Press edge: chaves 0000->0010 held 10 cycles -> exactly one jogada_feita pulse, 3 cycles after the change; change to 0110 without release -> no pulse; release then press -> one pulse.
REQ-036 Register priority: zeraR = 1 and registraR = 1 with chaves = 1111 -> db_chaves = 0.
REQ-037 Async reset: reset_n low between clock edges at count 9 with key register 4 -> all state clears immediately to the REQ-029 values.
